spi_frame_ctrl: RTL and testbench

- Sequences the MCU-to-FPGA SPI receive path in the system clock domain. cs is active-high and frames a transfer; data is shifted MSB-first on sck rising edges.
- Synchronizes sck, sdi and cs, and assembles whole bytes into a frame of up to MAX_BYTES bytes.
- Validates each frame and hands it to game logic over a valid/ready handshake.
- Sits between the MCU pins and the game-logic command decoder. Replaces the raw 8-bit capture with a framed, error-checked interface.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame receive path.
package spi_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DELIVER = 2'd2,
    SKIP    = 2'd3
  } state_e;

  // Bits per SPI byte.
  localparam int BYTE_BITS = 8;

  // Width of a counter able to hold 0..max_bytes.
  function automatic int len_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer chain and remember the
  // previous synchronized level for edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI receive-path frame controller: synchronizes the MCU pins, assembles
// MSB-first bytes into a frame, validates it on cs release and offers it to
// the game logic over a valid/ready handshake.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int MAX_BYTES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              sck_i,
  input  logic                              sdi_i,
  input  logic                              cs_i,
  output logic [MAX_BYTES*BYTE_BITS-1:0]    frame_data_o,
  output logic [len_width(MAX_BYTES)-1:0]   frame_len_o,
  output logic                              frame_valid_o,
  input  logic                              frame_ready_i,
  output logic                              busy_o,
  output logic                              err_pulse_o,
  output logic [7:0]                        err_cnt_o
);

  localparam int LW     = len_width(MAX_BYTES);
  localparam int DW     = MAX_BYTES * BYTE_BITS;
  // A single-flop synchronizer is not safe, so shallower settings are raised to 2.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [LW-1:0] MAX_CNT = LW'(MAX_BYTES);

  logic sck_sync_unused, sck_rise, sck_fall_unused;
  logic cs_sync, cs_rise, cs_fall;
  logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_N)) u_sync_sck (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (sck_i),
    .sync_o  (sck_sync_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_N)) u_sync_cs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (cs_i),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // sdi goes through the same depth as sck so a sampled bit lines up with
  // the sck edge that qualifies it.
  spi_sync_edge #(.STAGES(SYNC_N)) u_sync_sdi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (sdi_i),
    .sync_o  (sdi_sync),
    .rise_o  (sdi_rise_unused),
    .fall_o  (sdi_fall_unused)
  );

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            ovf_q, ovf_d;
  logic [DW-1:0]   frame_data_q, frame_data_d;
  logic [LW-1:0]   frame_len_q, frame_len_d;
  logic            frame_valid_q, frame_valid_d;
  logic            err_pulse_q, err_pulse_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      shift_next;
  logic            reject;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      buf_q         <= '0;
      ovf_q         <= 1'b0;
      frame_data_q  <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      buf_q         <= buf_d;
      ovf_q         <= ovf_d;
      frame_data_q  <= frame_data_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Next-state logic: byte assembly in RECV, frame validation on cs release,
  // handshake and lost-frame accounting in DELIVER.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    buf_d         = buf_q;
    ovf_d         = ovf_q;
    frame_data_d  = frame_data_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = frame_valid_q;
    err_pulse_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    shift_next    = {shift_q[6:0], sdi_sync};
    reject        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          buf_d      = '0;
          ovf_d      = 1'b0;
          state_d    = RECV;
        end
      end

      RECV: begin
        // The bit is taken before a coincident cs_fall closes the frame.
        if (sck_rise) begin
          shift_d = shift_next;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == MAX_CNT) begin
              ovf_d = 1'b1;
            end else begin
              for (int i = 0; i < MAX_BYTES; i++) begin
                if (byte_cnt_q == LW'(i)) begin
                  buf_d[i*BYTE_BITS +: BYTE_BITS] = shift_next;
                end
              end
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (cs_fall) begin
          if ((bit_cnt_d != 3'd0) || ovf_d) begin
            reject  = 1'b1;
            state_d = IDLE;
          end else if (byte_cnt_d == '0) begin
            state_d = IDLE;
          end else begin
            frame_data_d  = buf_d;
            frame_len_d   = byte_cnt_d;
            frame_valid_d = 1'b1;
            state_d       = DELIVER;
          end
        end
      end

      DELIVER: begin
        // A new transfer starting while the frame is pending is lost.
        if (cs_rise) begin
          reject = 1'b1;
        end
        if (frame_valid_q && frame_ready_i) begin
          frame_valid_d = 1'b0;
          state_d       = cs_sync ? SKIP : IDLE;
        end
      end

      SKIP: begin
        if (cs_fall) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (reject) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_data_o  = frame_data_q;
  assign frame_len_o   = frame_len_q;
  assign frame_valid_o = frame_valid_q;
  assign busy_o        = (state_q == RECV);
  assign err_pulse_o   = err_pulse_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed testbench for spi_frame_ctrl (MAX_BYTES = 4, SYNC_STAGES = 2).
module tb_spi_frame_ctrl;

   logic        clk;
   logic        reset;
   logic        sck;
   logic        sdi;
   logic        cs;
   logic [31:0] frameData;
   logic [2:0]  frameLen;
   logic        frameValid;
   logic        frameReady;
   logic        busy;
   logic        errPulse;
   logic [7:0]  errCnt;

   int checks = 0;
   int passes = 0;
   int errPulseTotal = 0;
   int validTotal = 0;

   spi_frame_ctrl #(.MAX_BYTES(4), .SYNC_STAGES(2)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .sck_i         (sck),
      .sdi_i         (sdi),
      .cs_i          (cs),
      .frame_data_o  (frameData),
      .frame_len_o   (frameLen),
      .frame_valid_o (frameValid),
      .frame_ready_i (frameReady),
      .busy_o        (busy),
      .err_pulse_o   (errPulse),
      .err_cnt_o     (errCnt)
   );

   // 100 MHz system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // running tallies of error-pulse cycles and frame_valid cycles
   always @(negedge clk) begin
      if (errPulse) errPulseTotal <= errPulseTotal + 1;
      if (frameValid) validTotal <= validTotal + 1;
   end

   // one comparison: count it, assert equality, report on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
   endtask

   // shift n bits of value MSB first with sck = clk/8
   task automatic applyStimulus(input int n, input logic [63:0] value);
      for (int i = n - 1; i >= 0; i--) begin
         sdi = value[i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic csOn();
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic csOff();
      repeat (4) @(negedge clk);
      cs = 1'b0;
   endtask

   // wait at most budget cycles for frame_valid; a timeout is a failed check
   task automatic waitValid(input string tag, input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (frameValid) found = 1;
      end
      if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int snapErr;
      int snapValid;
      reset = 1'b1;
      sck = 1'b0;
      sdi = 1'b0;
      cs = 1'b0;
      frameReady = 1'b1;
      repeat (3) @(negedge clk);

      // reset state
      checkOutput("rst_valid", 32'(frameValid), 32'd0);
      checkOutput("rst_data", frameData, 32'd0);
      checkOutput("rst_len", 32'(frameLen), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_errcnt", 32'(errCnt), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // single byte 0xA5 with exact latency from cs release
      csOn();
      checkOutput("t1_busy", 32'(busy), 32'd1);
      applyStimulus(8, 64'hA5);
      repeat (4) @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t1_valid_early", 32'(frameValid), 32'd0);
      @(negedge clk);
      checkOutput("t1_valid", 32'(frameValid), 32'd1);
      checkOutput("t1_len", 32'(frameLen), 32'd1);
      checkOutput("t1_data", frameData, 32'h0000_00A5);
      @(negedge clk);
      checkOutput("t1_valid_clear", 32'(frameValid), 32'd0);
      repeat (4) @(negedge clk);

      // four bytes
      csOn();
      applyStimulus(32, 64'h01020304);
      csOff();
      waitValid("t2", 20);
      checkOutput("t2_data", frameData, 32'h0403_0201);
      checkOutput("t2_len", 32'(frameLen), 32'd4);
      checkOutput("t2_errcnt", 32'(errCnt), 32'd0);
      repeat (4) @(negedge clk);

      // partial byte: 12 bits
      snapErr = errPulseTotal;
      snapValid = validTotal;
      csOn();
      applyStimulus(12, 64'hABC);
      csOff();
      repeat (10) @(negedge clk);
      checkOutput("t3_errcnt", 32'(errCnt), 32'd1);
      checkOutput("t3_pulse_cycles", 32'(errPulseTotal - snapErr), 32'd1);
      checkOutput("t3_no_valid", 32'(validTotal - snapValid), 32'd0);
      checkOutput("t3_idle", 32'(busy), 32'd0);

      // overflow: five bytes
      snapErr = errPulseTotal;
      snapValid = validTotal;
      csOn();
      applyStimulus(40, 64'h11_2233_4455);
      csOff();
      repeat (10) @(negedge clk);
      checkOutput("t4_errcnt", 32'(errCnt), 32'd2);
      checkOutput("t4_pulse_cycles", 32'(errPulseTotal - snapErr), 32'd1);
      checkOutput("t4_no_valid", 32'(validTotal - snapValid), 32'd0);

      // backpressure: pending 0x3C, a second frame is lost
      frameReady = 1'b0;
      csOn();
      applyStimulus(8, 64'h3C);
      csOff();
      waitValid("t5", 20);
      checkOutput("t5_data", frameData, 32'h0000_003C);
      repeat (4) @(negedge clk);
      csOn();
      checkOutput("t5_errcnt", 32'(errCnt), 32'd3);
      checkOutput("t5_hold_valid", 32'(frameValid), 32'd1);
      applyStimulus(4, 64'h5);
      checkOutput("t5_hold_data", frameData, 32'h0000_003C);
      frameReady = 1'b1;
      @(negedge clk);
      checkOutput("t5_transfer", 32'(frameValid), 32'd0);
      checkOutput("t5_skip_not_busy", 32'(busy), 32'd0);
      snapValid = validTotal;
      applyStimulus(4, 64'h5);
      csOff();
      repeat (12) @(negedge clk);
      checkOutput("t5_no_0x55", 32'(validTotal - snapValid), 32'd0);
      checkOutput("t5_errcnt_after", 32'(errCnt), 32'd3);
      csOn();
      applyStimulus(8, 64'h66);
      csOff();
      waitValid("t5b", 20);
      checkOutput("t5_third_data", frameData, 32'h0000_0066);
      checkOutput("t5_third_len", 32'(frameLen), 32'd1);
      repeat (4) @(negedge clk);

      // reset in the middle of a byte, then a clean frame
      csOn();
      applyStimulus(5, 64'h15);
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_data", frameData, 32'd0);
      checkOutput("t6_rst_len", 32'(frameLen), 32'd0);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_err", 32'(errPulse), 32'd0);
      checkOutput("t6_rst_errcnt", 32'(errCnt), 32'd0);
      checkOutput("t6_rst_valid", 32'(frameValid), 32'd0);
      cs = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      csOn();
      applyStimulus(8, 64'h7E);
      csOff();
      waitValid("t6", 20);
      checkOutput("t6_data", frameData, 32'h0000_007E);
      checkOutput("t6_len", 32'(frameLen), 32'd1);
      checkOutput("t6_errcnt", 32'(errCnt), 32'd0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
